dist_sdpram_mrport: RTL and testbench
=====================================

// Module: dist_sdpram_mrport
// PURPOSE
//  Single-clock distributed (LUT) simple-dual-port RAM, successor to the single-read-port SDP RAM.
//  Adds byte-lane write enables, 1-4 independent read ports, a selectable write/read collision mode,
//  per-port read-enable with valid flags, and an optional post-reset memory clear.
//  Used for small audio coefficient and scratch tables that several datapath stages read at once.
// PARAMETERS
//  ADDR_WIDTH  4            address width; legal range 4-10; DEPTH = 2**ADDR_WIDTH
//  DATA_WIDTH  16           word width; legal range 1-256
//  BYTE_WIDTH  8            lane width; NBE = ceil(DATA_WIDTH/BYTE_WIDTH); the top lane may be partial
//  RD_PORTS    2            number of read ports; legal range 1-4
//  OUT_REG     1            0 = combinational read; 1 = registered read with 1-cycle latency
//  RD_MODE     "READ_FIRST" collision mode: "READ_FIRST" or "WRITE_FIRST"
//  CLR_ON_RST  1            1 = zero every word after reset; 0 = contents survive reset
// PORTS
//  clk       in   1                      single clock; all logic on its rising edge
//  rst       in   1                      synchronous reset, active-high
//  wr_en     in   1                      write strobe; ignored while init_busy=1
//  wr_addr   in   ADDR_WIDTH             write address
//  wr_data   in   DATA_WIDTH             write data
//  wr_be     in   NBE                    lane enables; bit k covers wr_data[k*BYTE_WIDTH +: BYTE_WIDTH]
//  rd_en     in   RD_PORTS               per-port read request
//  rd_addr   in   RD_PORTS*ADDR_WIDTH    port p address = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]
//  rd_data   out  RD_PORTS*DATA_WIDTH    port p data = rd_data[p*DATA_WIDTH +: DATA_WIDTH]
//  rd_valid  out  RD_PORTS               per-port data-valid flag
//  init_busy out  1                      high while the clear sequence runs
// BEHAVIOUR
//  Reset values: rd_valid=0; registered rd_data=0; init_busy=CLR_ON_RST; clear counter=0.
//  Controller FSM, 2 states:
//   CLEAR: on each clk, write 0 to mem[clr_cnt] and increment clr_cnt. At clr_cnt=DEPTH-1 go to RUN
//     on the next edge, so CLEAR lasts exactly DEPTH cycles. init_busy=1 throughout.
//   RUN: normal operation with init_busy=0. rst in any state enters CLEAR (CLR_ON_RST=1) or RUN (=0).
//  Reset during CLEAR restarts the sequence at address 0.
//  Write in RUN with wr_en=1: for each lane k with wr_be[k]=1, mem[wr_addr] lane k <= wr_data lane k.
//   Other lanes keep their value. wr_be=0 with wr_en=1 leaves memory unchanged.
//  During CLEAR, wr_en and rd_en are ignored and rd_valid stays 0.
//  Read ports are fully independent. Any ports may share an address, and all of them get the same word.
//  OUT_REG=0:
//   rd_data[p] is the combinational value of mem[rd_addr[p]]; rd_valid[p] = rd_en[p] & ~init_busy.
//   WRITE_FIRST adds a bypass: if wr_en=1 and wr_addr=rd_addr[p], the enabled lanes show wr_data
//   in the same cycle. READ_FIRST shows the old word until the next edge.
//  OUT_REG=1:
//   On an edge where rd_en[p]=1 in RUN, rd_data[p] <= word and rd_valid[p] <= 1. Latency is 1 cycle.
//   If rd_en[p]=0, rd_valid[p] <= 0 and rd_data[p] holds its last value.
//   Collision (same edge, wr_en=1, wr_addr=rd_addr[p]): READ_FIRST captures the pre-write word.
//   WRITE_FIRST captures the merged word: new lanes where wr_be=1, old lanes elsewhere.
//  rst on the same edge as a write or read: rst wins, the write is dropped, rd_valid <= 0.
//  Addresses wrap naturally; there is no out-of-range condition.
// TESTING
//  T1 reset clear: CLR_ON_RST=1, AW=4. Pulse rst -> init_busy=1 for exactly 16 cycles; then all words read 0.
//  T2 byte enables: DW=16. Write 0xABCD at addr 3 with wr_be=2'b11, then 0x1234 with wr_be=2'b01.
//   Expect read of addr 3 = 0xAB34, returned 1 cycle after rd_en with OUT_REG=1.
//  T3 collision: mem[5]=0x0000. Same edge: write 0xFFFF to addr 5 and read addr 5.
//   Expect READ_FIRST -> 0x0000; WRITE_FIRST -> 0xFFFF.
//  T4 multi-port: RD_PORTS=4 read addrs 0,1,1,15 in the same cycle.
//   Expect 4 correct words, all rd_valid=1 next cycle; with rd_en=0 the data holds and rd_valid=0.
//  T5 reset mid-clear: assert rst at clr_cnt=7 -> sequence restarts at 0; init_busy lasts 16 more cycles.
//   Writes issued during CLEAR are lost.
//  T6 CLR_ON_RST=0: write 0x55 at addr 2, pulse rst -> init_busy stays 0; addr 2 still reads 0x55.

Source files
------------

// File: rtl/dist_sdpram_mrport_if.sv
// Bus bundle for dist_sdpram_mrport: one byte-lane write port, RD_PORTS
// read ports with flattened address/data buses, and the clear-busy flag.
//   master : drives the write port and read requests, samples read results
//   slave  : the RAM itself
interface dist_sdpram_mrport_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int NBE        = 2,
    parameter int RD_PORTS   = 2
);
    logic                           wr_en;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic [NBE-1:0]                 wr_be;
    logic [RD_PORTS-1:0]            rd_en;
    logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr;
    logic [RD_PORTS*DATA_WIDTH-1:0] rd_data;
    logic [RD_PORTS-1:0]            rd_valid;
    logic                           init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy
    );
endinterface

// File: rtl/dist_sdpram_mrport.sv
// Single-clock distributed simple-dual-port RAM with byte-lane writes and
// 1-4 independent read ports. Optional registered reads, READ_FIRST or
// WRITE_FIRST collision behaviour, and an optional post-reset clear that
// walks every address writing zero.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of dist_sdpram_mrport_if (write port, read ports,
//          rd_valid flags, init_busy)
module dist_sdpram_mrport #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_PORTS   = 2,
    parameter int OUT_REG    = 1,
    parameter     RD_MODE    = "READ_FIRST",
    parameter int CLR_ON_RST = 1
) (
    input logic                clk,
    input logic                rst,
    dist_sdpram_mrport_if.slave bus
);
    localparam int DEPTH       = 2 ** ADDR_WIDTH;
    localparam int NBE         = (DATA_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
    localparam bit WRITE_FIRST = (RD_MODE == "WRITE_FIRST");

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  run;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [NBE-1:0]        be;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] merged;
    logic                  wr_act;

    logic [RD_PORTS-1:0][ADDR_WIDTH-1:0] ra;
    logic [RD_PORTS-1:0][DATA_WIDTH-1:0] rd_word;

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLR_ON_RST != 0) ? S_CLEAR : S_RUN;
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
            if (clr_cnt == ADDR_WIDTH'(DEPTH - 1))
                state <= S_RUN;
        end
    end

    assign run           = (state == S_RUN);
    assign bus.init_busy = ~run;

    // ---------------- write path ----------------
    assign be = bus.wr_be;

    // Expand lane enables to a bit mask; the top lane may be partial.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            wmask[i] = be[i / BYTE_WIDTH];
    end

    // Word as it will look after this edge's write: new lanes where enabled.
    assign merged = (mem[bus.wr_addr] & ~wmask) | (bus.wr_data & wmask);
    assign wr_act = bus.wr_en & run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run)
                mem[clr_cnt] <= '0;
            else if (bus.wr_en)
                mem[bus.wr_addr] <= merged;
        end
    end

    // ---------------- read path ----------------
    assign ra = bus.rd_addr;

    // Per-port word seen by the read. WRITE_FIRST forwards the merged word
    // on an address match; READ_FIRST always sees the stored word.
    always_comb begin
        rd_word = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            if (WRITE_FIRST && wr_act && (bus.wr_addr == ra[p]))
                rd_word[p] = merged;
            else
                rd_word[p] = mem[ra[p]];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [RD_PORTS-1:0][DATA_WIDTH-1:0] data_q;
            logic [RD_PORTS-1:0]                 vld_q;

            // Data holds when a port is idle; only the valid flag drops.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                    vld_q  <= '0;
                end else begin
                    for (int p = 0; p < RD_PORTS; p++) begin
                        if (run && bus.rd_en[p]) begin
                            data_q[p] <= rd_word[p];
                            vld_q[p]  <= 1'b1;
                        end else begin
                            vld_q[p]  <= 1'b0;
                        end
                    end
                end
            end

            assign bus.rd_data  = data_q;
            assign bus.rd_valid = vld_q;
        end else begin : g_comb
            assign bus.rd_data  = rd_word;
            assign bus.rd_valid = bus.rd_en & {RD_PORTS{run}};
        end
    endgenerate
endmodule

// File: tb/tb_dist_sdpram_mrport.sv
module tb_dist_sdpram_mrport;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic [3:0]  rd_en;
    logic [15:0] rd_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Three variants: A registered/READ_FIRST/clear, B registered/WRITE_FIRST/
    // no clear, C combinational/WRITE_FIRST/clear. Bit i describes variant i.
    localparam logic [2:0] ORM = 3'b011;
    localparam logic [2:0] WFM = 3'b110;
    localparam logic [2:0] CLM = 3'b101;

    dist_sdpram_mrport_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NBE(2), .RD_PORTS(4)) ifa ();
    dist_sdpram_mrport_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NBE(2), .RD_PORTS(4)) ifb ();
    dist_sdpram_mrport_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NBE(2), .RD_PORTS(4)) ifc ();

    dist_sdpram_mrport #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RD_PORTS(4),
        .OUT_REG(1), .RD_MODE("READ_FIRST"), .CLR_ON_RST(1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    dist_sdpram_mrport #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RD_PORTS(4),
        .OUT_REG(1), .RD_MODE("WRITE_FIRST"), .CLR_ON_RST(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    dist_sdpram_mrport #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RD_PORTS(4),
        .OUT_REG(0), .RD_MODE("WRITE_FIRST"), .CLR_ON_RST(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    assign ifa.wr_en = wr_en; assign ifa.wr_addr = wr_addr; assign ifa.wr_data = wr_data;
    assign ifa.wr_be = wr_be; assign ifa.rd_en = rd_en;     assign ifa.rd_addr = rd_addr;
    assign ifb.wr_en = wr_en; assign ifb.wr_addr = wr_addr; assign ifb.wr_data = wr_data;
    assign ifb.wr_be = wr_be; assign ifb.rd_en = rd_en;     assign ifb.rd_addr = rd_addr;
    assign ifc.wr_en = wr_en; assign ifc.wr_addr = wr_addr; assign ifc.wr_data = wr_data;
    assign ifc.wr_be = wr_be; assign ifc.rd_en = rd_en;     assign ifc.rd_addr = rd_addr;

    logic [63:0] od [3];
    logic [3:0]  ov [3];
    logic        ob [3];
    assign od[0] = ifa.rd_data; assign ov[0] = ifa.rd_valid; assign ob[0] = ifa.init_busy;
    assign od[1] = ifb.rd_data; assign ov[1] = ifb.rd_valid; assign ob[1] = ifb.init_busy;
    assign od[2] = ifc.rd_data; assign ov[2] = ifc.rd_valid; assign ob[2] = ifc.init_busy;

    // ---------------- reference model ----------------
    logic [15:0] mm [3][16];   // memory image
    bit          kn [3][16];   // word content is known
    int          busy_left [3];
    logic [15:0] ed [3][4];    // registered-port expected data
    bit          ek [3][4];
    bit          ev [3][4];

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] b);
        return {b[1] ? n[15:8] : o[15:8], b[0] ? n[7:0] : o[7:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                if (CLM[i]) begin
                    busy_left[i] = 16;
                    for (int a = 0; a < 16; a++) begin mm[i][a] = 16'h0; kn[i][a] = 1'b1; end
                end else begin
                    busy_left[i] = 0;
                end
                for (int p = 0; p < 4; p++) begin
                    ev[i][p] = 1'b0;
                    ed[i][p] = 16'h0;
                    ek[i][p] = 1'b1;
                end
            end else if (busy_left[i] > 0) begin
                busy_left[i]--;
                for (int p = 0; p < 4; p++) ev[i][p] = 1'b0;
            end else begin
                for (int p = 0; p < 4; p++) begin
                    logic [3:0] a;
                    bit hit;
                    a   = rd_addr[p*4 +: 4];
                    hit = wr_en && (wr_addr == a) && WFM[i];
                    if (rd_en[p]) begin
                        ed[i][p] = hit ? merge(mm[i][a], wr_data, wr_be) : mm[i][a];
                        ek[i][p] = kn[i][a] || (hit && wr_be == 2'b11);
                        ev[i][p] = 1'b1;
                    end else begin
                        ev[i][p] = 1'b0;
                    end
                end
                if (wr_en) begin
                    mm[i][wr_addr] = merge(mm[i][wr_addr], wr_data, wr_be);
                    kn[i][wr_addr] = kn[i][wr_addr] || (wr_be == 2'b11);
                end
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy[%0d]", i), 64'(ob[i]), 64'(busy_left[i] > 0));
            for (int p = 0; p < 4; p++) begin
                if (ORM[i]) begin
                    chk($sformatf("valid[%0d][%0d]", i, p), 64'(ov[i][p]), 64'(ev[i][p]));
                    if (ek[i][p])
                        chk($sformatf("data[%0d][%0d]", i, p), 64'(od[i][p*16 +: 16]), 64'(ed[i][p]));
                end else begin
                    logic [3:0]  a;
                    logic [15:0] w;
                    bit v, hit, k;
                    a   = rd_addr[p*4 +: 4];
                    v   = rd_en[p] && (busy_left[i] == 0);
                    hit = wr_en && (wr_addr == a) && WFM[i];
                    w   = hit ? merge(mm[i][a], wr_data, wr_be) : mm[i][a];
                    k   = kn[i][a] || (hit && wr_be == 2'b11);
                    chk($sformatf("valid[%0d][%0d]", i, p), 64'(ov[i][p]), 64'(v));
                    if (v && k)
                        chk($sformatf("data[%0d][%0d]", i, p), 64'(od[i][p*16 +: 16]), 64'(w));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = 4'h0; wr_data = 16'h0; wr_be = 2'b00;
        rd_en = 4'h0; rd_addr = 16'h0;
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (ob[0] && n < 40) begin
            n++;
            tick();
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic [3:0]  ra;
        logic [15:0] ea;   // A: registered READ_FIRST
        logic [15:0] eb;   // B: registered WRITE_FIRST
        logic [15:0] ec;   // C: combinational WRITE_FIRST (after the edge)
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n;
        tbl[0] = '{1'b1, 4'd3,  16'hABCD, 2'b11, 4'd3,  16'h0000, 16'hABCD, 16'hABCD};
        tbl[1] = '{1'b1, 4'd3,  16'h1234, 2'b01, 4'd3,  16'hABCD, 16'hAB34, 16'hAB34};
        tbl[2] = '{1'b0, 4'd0,  16'h0000, 2'b00, 4'd3,  16'hAB34, 16'hAB34, 16'hAB34};
        tbl[3] = '{1'b1, 4'd5,  16'hFFFF, 2'b11, 4'd5,  16'h0000, 16'hFFFF, 16'hFFFF};
        tbl[4] = '{1'b0, 4'd0,  16'h0000, 2'b00, 4'd5,  16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[5] = '{1'b1, 4'd5,  16'h0000, 2'b00, 4'd5,  16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[6] = '{1'b1, 4'd5,  16'h00AA, 2'b10, 4'd5,  16'hFFFF, 16'h00FF, 16'h00FF};
        tbl[7] = '{1'b0, 4'd0,  16'h0000, 2'b00, 4'd5,  16'h00FF, 16'h00FF, 16'h00FF};
        tbl[8] = '{1'b1, 4'd15, 16'hBEEF, 2'b11, 4'd14, 16'h0000, 16'h0000, 16'h0000};
        tbl[9] = '{1'b0, 4'd0,  16'h0000, 2'b00, 4'd15, 16'hBEEF, 16'hBEEF, 16'hBEEF};

        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // T1: clear lasts exactly 16 cycles, then every word reads zero
        count_busy(n);
        chk("t1_busy_cycles", 64'(n), 64'd16);
        for (int g = 0; g < 4; g++) begin
            rd_en   = 4'hF;
            rd_addr = {4'(g*4+3), 4'(g*4+2), 4'(g*4+1), 4'(g*4)};
            tick();
            chk($sformatf("t1_zero_%0d", g), od[0], 64'h0);
        end
        idle();

        // Give the no-clear variant a known image too
        for (int a = 0; a < 16; a++) write(4'(a), 16'h0, 2'b11);

        // T2/T3 and lane corners from the table, port 0 only
        for (int r = 0; r < 10; r++) begin
            wr_en = tbl[r].we; wr_addr = tbl[r].wa; wr_data = tbl[r].wd; wr_be = tbl[r].be;
            rd_en = 4'b0001;   rd_addr = {12'h0, tbl[r].ra};
            tick();
            chk($sformatf("vec%0d_a", r), 64'(od[0][15:0]), 64'(tbl[r].ea));
            chk($sformatf("vec%0d_b", r), 64'(od[1][15:0]), 64'(tbl[r].eb));
            chk($sformatf("vec%0d_c", r), 64'(od[2][15:0]), 64'(tbl[r].ec));
            chk($sformatf("vec%0d_v", r), 64'(ov[0][0]), 64'd1);
        end
        idle();

        // T4: four ports, shared address, then hold
        write(4'd0,  16'h1111, 2'b11);
        write(4'd1,  16'h2222, 2'b11);
        write(4'd15, 16'h3333, 2'b11);
        rd_en = 4'hF; rd_addr = {4'd15, 4'd1, 4'd1, 4'd0};
        tick();
        chk("t4_valid", 64'(ov[0]), 64'hF);
        chk("t4_data", od[0], 64'h3333_2222_2222_1111);
        rd_en = 4'h0; rd_addr = 16'h5A3C;
        tick();
        chk("t4_hold_valid", 64'(ov[0]), 64'h0);
        chk("t4_hold_data", od[0], 64'h3333_2222_2222_1111);
        idle();

        // T5: reset at clear count 7 restarts the sweep; clear-time write is lost
        rst = 1'b1; tick(); rst = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h1111; wr_be = 2'b11;
        tick();
        idle();
        for (int c = 0; c < 6; c++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        count_busy(n);
        chk("t5_busy_cycles", 64'(n), 64'd16);
        rd_en = 4'b0001; rd_addr = 16'h0002;
        tick();
        chk("t5_lost_write", 64'(od[0][15:0]), 64'h0);
        idle();

        // T6: no-clear variant keeps contents across reset
        write(4'd2, 16'h0055, 2'b11);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_busy", 64'(ob[1]), 64'h0);
        rd_en = 4'b0001; rd_addr = 16'h0002;
        tick();
        chk("t6_keep", 64'(od[1][15:0]), 64'h0055);
        idle();
        count_busy(n);

        // Random traffic with forced collisions and rare resets
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 99) == 0);
            wr_en   = $urandom_range(0, 1) == 1;
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 16'($urandom);
            wr_be   = 2'($urandom_range(0, 3));
            rd_en   = 4'($urandom_range(0, 15));
            for (int p = 0; p < 4; p++)
                rd_addr[p*4 +: 4] = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
